// File: rtl/output_requant_buffer.sv
// output_requant_buffer: requantizes accumulator results (ReLU, shift, saturate) and buffers them in a FIFO
module output_requant_buffer #(
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int IO_DATA_WIDTH      = 16,
    parameter int FIFO_DEPTH         = 8,
    parameter int FEATURE_MAP_WIDTH  = 128,
    parameter int FEATURE_MAP_HEIGHT = 128,
    parameter int OUTPUT_NB_CHANNELS = 16
) (
    input  logic                                 clk,
    input  logic                                 arst_n_in,
    input  logic                                 start,
    input  logic [4:0]                           shift,
    input  logic                                 relu_en,
    input  logic signed [ACCUMULATION_WIDTH-1:0] in_data,
    input  logic                                 in_valid,
    input  logic [31:0]                          in_x,
    input  logic [31:0]                          in_y,
    input  logic [31:0]                          in_ch,
    output logic signed [IO_DATA_WIDTH-1:0]      out_data,
    output logic [31:0]                          out_x,
    output logic [31:0]                          out_y,
    output logic [31:0]                          out_ch,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 overflow,
    output logic [31:0]                          count,
    output logic                                 done
);
    localparam int AW = ACCUMULATION_WIDTH;
    localparam int IW = IO_DATA_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = IW + 96;
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [31:0] TOTAL = 32'(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS);
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-IW+1){1'b0}}, {(IW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-IW+1){1'b1}}, {(IW-1){1'b0}}};

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e              state_q, state_d;
    logic                s1_valid_q, s1_valid_d;
    logic [EW-1:0]       s1_entry_q, s1_entry_d;
    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]         occ_q, occ_d;
    logic                overflow_q, overflow_d;
    logic [31:0]         count_q, count_d;
    logic                done_q, done_d;
    logic signed [AW-1:0] relu_v, shr_v;
    logic [IW-1:0]       sat_v;
    logic                pop, push_ok;
    logic [EW-1:0]       head;

    assign out_valid = occ_q != '0;
    assign pop       = out_valid && out_ready;
    assign push_ok   = s1_valid_q && (occ_q != FULL || pop);
    assign head      = mem_q[rd_ptr_q];
    assign {out_data, out_x, out_y, out_ch} = out_valid ? head : '0;
    assign overflow  = overflow_q;
    assign count     = count_q;
    assign done      = done_q;

    // Requantization: ReLU, arithmetic shift, then clamp to the output range
    always_comb begin
        relu_v = (relu_en && in_data[AW-1]) ? '0 : in_data;
        shr_v  = relu_v >>> shift;
        sat_v  = (shr_v > SAT_MAX) ? SAT_MAX[IW-1:0] : (shr_v < SAT_MIN) ? SAT_MIN[IW-1:0] : shr_v[IW-1:0];
    end

    // Next-state for stage 1, FIFO pointers, flags and the IDLE/ACTIVE machine
    always_comb begin
        s1_valid_d = in_valid;
        s1_entry_d = {sat_v, in_x, in_y, in_ch};
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        occ_d      = occ_q + (PW+1)'(push_ok) - (PW+1)'(pop);
        overflow_d = overflow_q | (s1_valid_q && !push_ok);
        count_d    = (in_valid && count_q != '1) ? count_q + 32'd1 : count_q;
        state_d    = state_q;
        done_d     = done_q;
        if (start) begin
            s1_valid_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            occ_d      = '0;
            overflow_d = 1'b0;
            count_d    = '0;
            done_d     = 1'b0;
            state_d    = ACTIVE;
        end else if (state_q == ACTIVE && count_d == TOTAL && !s1_valid_d && occ_d == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q    <= IDLE;
            s1_valid_q <= 1'b0;
            s1_entry_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
            count_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_entry_q <= s1_entry_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            done_q     <= done_d;
        end
    end

    // FIFO storage; contents only matter where occupancy says they are valid
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= s1_entry_q;
    end
endmodule

// File: doc/output_requant_buffer.md
OUTPUT_REQUANT_BUFFER -- requirements
Module: output_requant_buffer

Interface
REQ-001 Parameter ACCUMULATION_WIDTH, default 32, width of the incoming accumulated result.
REQ-002 Parameter IO_DATA_WIDTH, default 16, width of the requantized output.
REQ-003 Parameter FIFO_DEPTH, default 8, number of output entries buffered; power of two, at least 2.
REQ-004 Parameters FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT and OUTPUT_NB_CHANNELS, defaults 128, 128 and 16; TOTAL = their product.
REQ-005 Port clk, input, 1, the only clock; all state is on its rising edge.
REQ-006 Port arst_n_in, input, 1, asynchronous active-low reset.
REQ-007 Port start, input, 1, single-cycle pulse that begins a new layer.
REQ-008 Port shift, input, 5, right-shift amount; sampled with each input beat.
REQ-009 Port relu_en, input, 1, enables ReLU; sampled with each input beat.
REQ-010 Port in_data, input, ACCUMULATION_WIDTH, signed accumulated result from the convolution core.
REQ-011 Port in_valid, input, 1, qualifies in_data, in_x, in_y and in_ch; there is no backpressure to the core.
REQ-012 Ports in_x, in_y and in_ch, input, 32 each, coordinates of the result.
REQ-013 Port out_data, output, IO_DATA_WIDTH, signed requantized value at the FIFO head.
REQ-014 Ports out_x, out_y and out_ch, output, 32 each, coordinates of the FIFO head entry.
REQ-015 Port out_valid, output, 1, set whenever the FIFO is non-empty.
REQ-016 Port out_ready, input, 1, consumer ready; a beat transfers when out_valid and out_ready are both 1.
REQ-017 Port overflow, output, 1, sticky flag set when an entry is dropped.
REQ-018 Port count, output, 32, number of in_valid beats received since the last start.
REQ-019 Port done, output, 1, sticky flag marking that the layer has been fully drained.

Function
REQ-020 Datapath order: ReLU, then arithmetic right shift by shift (truncation toward minus infinity), then saturation to the signed IO_DATA_WIDTH range [-32768, 32767].
REQ-021 With relu_en=1, a negative in_data yields 0.
REQ-022 Stage 1: on an in_valid beat, the requantized value and its coordinates are registered; this is the single pipeline stage.
REQ-023 Stage 2: the stage-1 entry is pushed into the FIFO on the next edge.
REQ-024 Latency: a beat presented in cycle N into an empty FIFO appears with out_valid=1 in cycle N+2.
REQ-025 The FIFO head is driven from storage with no combinational path from in_* to out_*.
REQ-026 Ordering is strictly first-in first-out.
REQ-027 A push with the FIFO full and no pop in the same cycle drops the entry, sets overflow, and leaves FIFO contents unchanged.
REQ-028 A push and a pop in the same cycle with the FIFO full are both accepted: occupancy stays FIFO_DEPTH and overflow is not set.
REQ-029 A pop with the FIFO empty has no effect.
REQ-030 Read and write pointers wrap modulo FIFO_DEPTH.
REQ-031 count increments on every in_valid beat, including dropped ones, and saturates at 2^32-1.
REQ-032 done is set when count equals TOTAL, stage 1 is empty and the FIFO is empty; done stays set until start or reset.
REQ-033 start clears count, overflow and done, empties stage 1 and the FIFO, and ignores an in_valid beat in the same cycle.
REQ-034 The block behaves as a two-state machine, IDLE and ACTIVE; start moves it to ACTIVE, and done=1 returns it to IDLE.
REQ-035 in_valid beats while in IDLE are processed normally, but done is not asserted until after a start.

Reset
REQ-036 Asynchronous assertion of arst_n_in sets out_valid, overflow, done and count to 0, empties the FIFO and stage 1, and sets the state to IDLE.
REQ-037 While in reset, out_data and the out coordinates are 0.
REQ-038 Reset mid-operation discards all buffered entries; after release the block accepts beats normally.

Verification
REQ-039 shift=4, relu_en=0, in_data=0x00001234 in cycle N -> out_data=0x0123 with out_valid=1 in cycle N+2.
REQ-040 shift=0: in_data=0x7FFFFFFF -> 0x7FFF, and 0x80000000 -> 0x8000; shift=1, in_data=-3 -> -2; relu_en=1, in_data=-5 -> 0.
REQ-041 out_ready=0 and 9 beats with values 1 to 9 -> overflow=1, then draining yields 1 to 8 in order and the FIFO is empty.
REQ-042 FIFO full, out_ready=1 and in_valid=1 each cycle for 20 cycles -> overflow stays 0 and the outputs are an unbroken ordered sequence.
REQ-043 Parameters 2x2x2 (TOTAL=8), start, then 8 beats with out_ready=1 -> done=1 one cycle after the last pop; a subsequent start -> done=0 and count=0.
REQ-044 Reset asserted with 5 entries buffered -> out_valid=0 immediately; after release, 1 beat yields exactly 1 output.
